// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: turns M-stage load/store controls into a ready-based
// data-memory transaction, stalls the pipeline while it is in flight and formats load data.
module mem_stage_lsu #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        MemReadM,
  input  logic        MemWriteM,
  input  logic [2:0]  Funct3M,
  input  logic [31:0] ALUResultM,
  input  logic [31:0] WriteDataM,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ready,
  input  logic [31:0] mem_rdata,
  output logic [31:0] ReadData,
  output logic        StallM,
  output logic        MisalignM,
  output logic        BusErrM
);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  state_t      state, state_nxt;
  logic [7:0]  cnt;
  logic [2:0]  f3_p1;
  logic [1:0]  lo_p1;
  logic        req, legal, aligned, acc, timeout_hit;

  function automatic logic [31:0] load_fmt(input logic [2:0] f3, input logic [1:0] lo,
                                           input logic [31:0] w);
    logic signed [7:0]  b;
    logic signed [15:0] h;
    logic [31:0]        r;
    b = w[{lo, 3'b000} +: 8];
    h = w[{lo[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  r = 32'(b);
      3'b100:  r = {24'b0, b};
      3'b001:  r = 32'(h);
      3'b101:  r = {16'b0, h};
      default: r = w;
    endcase
    return r;
  endfunction

  function automatic logic [3:0] store_be(input logic [2:0] f3, input logic [1:0] lo);
    case (f3[1:0])
      2'b00:   return 4'b0001 << lo;
      2'b01:   return 4'b0011 << {lo[1], 1'b0};
      default: return 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] store_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return {4{d[7:0]}};
      2'b01:   return {2{d[15:0]}};
      default: return d;
    endcase
  endfunction

  always_comb begin
    req   = MemReadM | MemWriteM;
    legal = (Funct3M == 3'b000) || (Funct3M == 3'b001) || (Funct3M == 3'b010) ||
            (Funct3M == 3'b100) || (Funct3M == 3'b101);
    case (Funct3M[1:0])
      2'b00:   aligned = 1'b1;
      2'b01:   aligned = ~ALUResultM[0];
      2'b10:   aligned = (ALUResultM[1:0] == 2'b00);
      default: aligned = 1'b0;
    endcase
    acc         = req & legal & aligned;
    timeout_hit = (TIMEOUT != 0) && (cnt == LAST_CNT);
  end

  always_comb begin
    state_nxt = state;
    StallM    = 1'b0;
    MisalignM = 1'b0;
    case (state)
      IDLE: begin
        StallM    = acc;
        MisalignM = req & legal & ~aligned;
        if (acc) state_nxt = BUSY;
      end
      BUSY: begin
        StallM = 1'b1;
        if (mem_ready || timeout_hit) state_nxt = DONE;
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Stage p1: bus request registers and formatted load data
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      ReadData  <= '0;
      BusErrM   <= 1'b0;
      f3_p1     <= '0;
      lo_p1     <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          ReadData <= '0;
          BusErrM  <= 1'b0;
          if (acc) begin
            mem_req   <= 1'b1;
            mem_we    <= MemWriteM;
            mem_addr  <= {ALUResultM[31:2], 2'b00};
            mem_wdata <= MemWriteM ? store_wdata(Funct3M, WriteDataM) : '0;
            mem_be    <= MemWriteM ? store_be(Funct3M, ALUResultM[1:0]) : 4'b0000;
            f3_p1     <= Funct3M;
            lo_p1     <= ALUResultM[1:0];
            cnt       <= '0;
          end
        end
        BUSY: begin
          cnt <= cnt + 8'd1;
          // A completing access takes priority over an expiring timeout
          if (mem_ready) begin
            mem_req  <= 1'b0;
            ReadData <= mem_we ? '0 : load_fmt(f3_p1, lo_p1, mem_rdata);
          end else if (timeout_hit) begin
            mem_req  <= 1'b0;
            ReadData <= '0;
            BusErrM  <= 1'b1;
          end
        end
        DONE:    BusErrM <= 1'b0;
        default: BusErrM <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Bench for mem_stage_lsu: transaction-level expectations computed per access, checked
// every cycle on the falling edge, plus directed accesses with hand-computed literals.
module tb_mem_stage_lsu;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        MemReadM, MemWriteM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ready;
  logic [31:0] mem_rdata;
  logic [31:0] ReadData;
  logic        StallM, MisalignM, BusErrM;

  mem_stage_lsu #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .MemReadM(MemReadM), .MemWriteM(MemWriteM), .Funct3M(Funct3M),
    .ALUResultM(ALUResultM), .WriteDataM(WriteDataM), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be), .mem_ready(mem_ready),
    .mem_rdata(mem_rdata), .ReadData(ReadData), .StallM(StallM), .MisalignM(MisalignM),
    .BusErrM(BusErrM)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  bit          chk_on = 0;
  bit          exp_stall, exp_mis, exp_req, exp_bus, exp_we, exp_zero;
  logic [31:0] exp_rd, exp_addr, exp_wd, prev_rd;
  logic [3:0]  exp_be;
  bit          lit_on = 0;
  int          lit_sel;
  logic [31:0] lit_val;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h want %h at %0t", nm, act, expv, $time);
    end
  endtask

  always @(negedge clk) begin
    if (chk_on) begin
      chk("StallM", 32'(StallM), 32'(exp_stall));
      chk("MisalignM", 32'(MisalignM), 32'(exp_mis));
      chk("BusErrM", 32'(BusErrM), 32'(exp_bus));
      chk("mem_req", 32'(mem_req), 32'(exp_req));
      chk("ReadData", ReadData, exp_rd);
      if (exp_req) begin
        chk("mem_we", 32'(mem_we), 32'(exp_we));
        chk("mem_addr", mem_addr, exp_addr);
        chk("mem_be", 32'(mem_be), 32'(exp_be));
        if (exp_we) chk("mem_wdata", mem_wdata, exp_wd);
      end
      if (exp_zero) begin
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
      end
      if (lit_on) begin
        case (lit_sel)
          0:       chk("lit_ReadData", ReadData, lit_val);
          1:       chk("lit_mem_wdata", mem_wdata, lit_val);
          2:       chk("lit_mem_be", 32'(mem_be), lit_val);
          default: chk("lit_BusErrM", 32'(BusErrM), lit_val);
        endcase
      end
    end
  end

  function automatic logic [31:0] m_load(input logic [2:0] f3, input logic [31:0] a,
                                         input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (a % 4))) & 32'd255;
    h = (w >> (16 * ((a / 2) % 2))) & 32'd65535;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFFFF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF0000 : h;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] a);
    case (f3[1:0])
      2'd0:    return 4'(32'd1 << (a % 4));
      2'd1:    return 4'(32'd3 << (a % 4));
      default: return 4'd15;
    endcase
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] d);
    case (f3[1:0])
      2'd0:    return (d & 32'hFF) * 32'h01010101;
      2'd1:    return (d & 32'hFFFF) * 32'h00010001;
      default: return d;
    endcase
  endfunction

  task automatic idle();
    MemReadM = 0; MemWriteM = 0; Funct3M = 0; ALUResultM = 0; WriteDataM = 0;
    mem_ready = 0; mem_rdata = 0;
  endtask

  task automatic scramble();
    MemReadM = 1'($urandom); MemWriteM = 1'($urandom); Funct3M = 3'($urandom);
    ALUResultM = $urandom; WriteDataM = $urandom;
  endtask

  // One M-stage access: IDLE cycle, BUSY cycles, DONE cycle (or reset abort)
  task automatic txn(input bit rd, input bit wr, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] d, input int dly, input logic [31:0] rdata,
                     input int rst_at, input int lsel, input logic [31:0] lval);
    bit req, legal, algn, acc, timed;
    int nb;
    req   = rd | wr;
    legal = f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    algn  = (a % (32'd1 << f3[1:0])) == 0;
    acc   = req && legal && algn;
    MemReadM = rd; MemWriteM = wr; Funct3M = f3; ALUResultM = a; WriteDataM = d;
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    exp_stall = acc; exp_mis = req && legal && !algn; exp_req = 0; exp_bus = 0;
    exp_rd = prev_rd; exp_zero = 0; lit_on = 0;
    @(posedge clk); #1;
    if (!acc) begin
      prev_rd = 0;
      return;
    end
    timed = (TO != 0) && (dly > TO);
    nb = timed ? TO : dly;
    for (int k = 1; k <= nb; k++) begin
      scramble();
      mem_ready = (k == dly);
      mem_rdata = (k == dly) ? rdata : $urandom;
      exp_stall = 1; exp_req = 1; exp_mis = 0; exp_bus = 0; exp_rd = 0;
      exp_we = wr; exp_addr = a & ~32'd3; exp_be = wr ? m_be(f3, a) : 4'd0;
      exp_wd = m_wdata(f3, d);
      lit_on = (lsel == 1 || lsel == 2) && k == 1; lit_sel = lsel; lit_val = lval;
      if (k == rst_at) rst = 1;
      @(posedge clk); #1;
      if (k == rst_at) begin
        rst = 0; idle();
        exp_stall = 0; exp_req = 0; exp_mis = 0; exp_bus = 0; exp_rd = 0;
        exp_zero = 1; lit_on = 0;
        @(posedge clk); #1;
        exp_zero = 0; prev_rd = 0;
        return;
      end
    end
    scramble();
    mem_ready = 1'($urandom); mem_rdata = $urandom;
    exp_stall = 0; exp_req = 0; exp_mis = 0; exp_bus = timed;
    exp_rd = (timed || wr) ? 32'd0 : m_load(f3, a, rdata);
    lit_on = (lsel == 0 || lsel == 3); lit_sel = lsel; lit_val = lval;
    @(posedge clk); #1;
    lit_on = 0;
    prev_rd = exp_rd;
  endtask

  initial begin
    int op, dly, rat;
    bit rd, wr;
    logic [2:0] f3;
    logic [31:0] a;
    rst = 1; idle();
    exp_stall = 0; exp_mis = 0; exp_req = 0; exp_bus = 0; exp_we = 0; exp_zero = 1;
    exp_rd = 0; exp_addr = 0; exp_wd = 0; exp_be = 0; prev_rd = 0;
    lit_sel = 0; lit_val = 0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 0; chk_on = 1;
    @(posedge clk); #1;
    exp_zero = 0;

    txn(1, 0, 3'b010, 32'h104, 0, 1, 32'hDEADBEEF, 0, 0, 32'hDEADBEEF);
    txn(1, 0, 3'b000, 32'h103, 0, 1, 32'h80123456, 0, 0, 32'hFFFFFF80);
    txn(1, 0, 3'b100, 32'h103, 0, 2, 32'h80123456, 0, 0, 32'h00000080);
    txn(1, 0, 3'b101, 32'h102, 0, 1, 32'h80123456, 0, 0, 32'h00008012);
    txn(1, 0, 3'b001, 32'h102, 0, 1, 32'h80123456, 0, 0, 32'hFFFF8012);
    txn(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 1, 0, 0, 1, 32'hABCDABCD);
    txn(0, 1, 3'b001, 32'h22, 32'h0000ABCD, 3, 0, 0, 2, 32'h0000000C);
    txn(1, 1, 3'b000, 32'h41, 32'h000000A5, 1, 0, 0, 1, 32'hA5A5A5A5);
    txn(1, 0, 3'b010, 32'h106, 0, 1, 0, 0, -1, 0);
    txn(1, 0, 3'b011, 32'h100, 0, 1, 0, 0, -1, 0);
    txn(1, 0, 3'b010, 32'h300, 0, 100, 32'h12345678, 0, 3, 32'd1);
    txn(1, 0, 3'b010, 32'h304, 0, TO, 32'h12345678, 0, 0, 32'h12345678);
    txn(1, 0, 3'b010, 32'h200, 0, 100, 0, 2, -1, 0);

    for (int i = 0; i < 400; i++) begin
      op = $urandom_range(0, 9);
      rd = (op >= 1 && op <= 5) || op == 9;
      wr = op >= 6;
      f3 = 3'($urandom);
      a = $urandom;
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      dly = $urandom_range(1, TO + 2);
      rat = ($urandom_range(0, 24) == 0) ? $urandom_range(1, 3) : 0;
      txn(rd, wr, f3, a, $urandom, dly, $urandom, rat, -1, 0);
    end

    idle();
    exp_stall = 0; exp_mis = 0; exp_req = 0; exp_bus = 0; exp_rd = prev_rd;
    @(negedge clk); #1;
    chk_on = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
